// File: rtl/sha_stream_requestor_pkg.sv
// Shared CCI-P subset, requestor FSM encodings, DSM status codes and the request-length helper.
package sha_stream_requestor_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_WRLINE = 4'h1
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_clLen  cl_len;
        t_ccip_clAddr address;
        logic [15:0]  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic               valid;
        t_ccip_c0_ReqMemHdr hdr;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic         sop;
        t_ccip_clLen  cl_len;
        t_ccip_clAddr address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic               valid;
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c0_rsp resp_type;
        logic [1:0]   cl_num;
        logic [15:0]  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic               rspValid;
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    localparam logic [31:0] HC_CONTROL_START = 32'h0000_0003;
    localparam logic [31:0] DSM_OK  = 32'd1;
    localparam logic [31:0] DSM_ERR = 32'd2;

    typedef logic [1:0] t_rd_state2;
    localparam t_rd_state2 RD_IDLE  = 2'd0;
    localparam t_rd_state2 RD_FETCH = 2'd1;
    localparam t_rd_state2 RD_DRAIN = 2'd2;

    typedef logic [1:0] t_wr_state2;
    localparam t_wr_state2 WR_IDLE   = 2'd0;
    localparam t_wr_state2 WR_DIGEST = 2'd1;
    localparam t_wr_state2 WR_DSM    = 2'd2;

    function automatic t_ccip_clLen cl_len_for(input int n);
        case (n)
            4:       return eCL_LEN_4;
            2:       return eCL_LEN_2;
            default: return eCL_LEN_1;
        endcase
    endfunction

endpackage

// File: rtl/sha_stream_requestor_if.sv
// Bundles the CCI-P channels and the hash-core stream seen by the requestor.
interface sha_stream_requestor_if #(parameter int DIGEST_W = 512);
    import sha_stream_requestor_pkg::*;

    t_if_ccip_Rx           ccip_rx;
    t_if_ccip_c0_Tx        ccip_c0_tx;
    t_if_ccip_c1_Tx        ccip_c1_tx;
    logic [511:0]          block;
    logic                  block_valid;
    logic                  block_ready;
    logic [DIGEST_W-1:0]   digest;
    logic                  digest_valid;

    modport master (input  ccip_rx, block_ready, digest, digest_valid,
                    output ccip_c0_tx, ccip_c1_tx, block, block_valid);
    modport slave  (output ccip_rx, block_ready, digest, digest_valid,
                    input  ccip_c0_tx, ccip_c1_tx, block, block_valid);
endinterface

// File: rtl/sha_stream_requestor_reorder_buf.sv
// Reorder buffer: lines fill by slot index in any order and drain strictly in allocation order.
// Head slot is presented straight from storage flops; a slot stays valid until drained.
module sha_reorder_buf
    import sha_stream_requestor_pkg::*;
#(
    parameter int BUF_DEPTH  = 8,
    parameter int CL_PER_REQ = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         alloc_vld,
    output logic [$clog2(BUF_DEPTH)-1:0] alloc_idx,
    output logic [$clog2(BUF_DEPTH):0]   free_cnt,
    output logic                         empty,
    input  logic                         fill_vld,
    input  logic [$clog2(BUF_DEPTH)-1:0] fill_idx,
    input  t_ccip_clData                 fill_dat,
    input  logic                         drain_vld,
    output logic                         head_vld,
    output t_ccip_clData                 head_dat
);
    localparam int IW = $clog2(BUF_DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]        alloc_q, alloc_d, drain_q, drain_d;
    logic [BUF_DEPTH-1:0] vld_q, vld_d;
    t_ccip_clData         mem_q [BUF_DEPTH];
    t_ccip_clData         mem_d [BUF_DEPTH];

    assign alloc_idx = alloc_q[IW-1:0];
    assign free_cnt  = PW'(BUF_DEPTH) - (alloc_q - drain_q);
    assign empty     = (alloc_q == drain_q);
    assign head_vld  = vld_q[drain_q[IW-1:0]];
    assign head_dat  = mem_q[drain_q[IW-1:0]];

    // Fill and drain never target the same slot, so both updates can land together.
    always_comb begin
        alloc_d = alloc_q;
        drain_d = drain_q;
        vld_d   = vld_q;
        mem_d   = mem_q;
        if (alloc_vld) alloc_d = alloc_q + PW'(CL_PER_REQ);
        if (drain_vld) begin
            vld_d[drain_q[IW-1:0]] = 1'b0;
            drain_d = drain_q + PW'(1);
        end
        if (fill_vld) begin
            vld_d[fill_idx] = 1'b1;
            mem_d[fill_idx] = fill_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alloc_q <= '0;
            drain_q <= '0;
            vld_q   <= '0;
        end else begin
            alloc_q <= alloc_d;
            drain_q <= drain_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sha_stream_requestor.sv
// Streams a source buffer through the reorder buffer into the hash core, then writes the
// digest lines and a DSM completion word; CCI-P almost-full and block_ready stall it.
module sha_stream_requestor
    import sha_stream_requestor_pkg::*;
#(
    parameter int BUF_DEPTH  = 8,
    parameter int CL_PER_REQ = 2,
    parameter int DIGEST_W   = 512
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [31:0]                   hc_control,
    input  t_ccip_clAddr                  hc_dsm_base,
    input  t_ccip_clAddr                  src_addr,
    input  t_ccip_clAddr                  src_size,
    input  t_ccip_clAddr                  dst_addr,
    sha_stream_requestor_if.master        bus,
    output logic                          busy,
    output logic                          error
);
    localparam int IW = $clog2(BUF_DEPTH);
    localparam int PW = IW + 1;
    localparam int DL = DIGEST_W / 512;
    localparam int KW = (DL > 1) ? $clog2(DL) : 1;

    t_rd_state2     rd_state_q, rd_state_d;
    t_wr_state2     wr_state_q, wr_state_d;
    t_ccip_clAddr   rd_cnt_q, rd_cnt_d, dlv_cnt_q, dlv_cnt_d;
    t_ccip_clAddr   size_q, size_d, src_q, src_d, dst_q, dst_d, dsm_q, dsm_d;
    logic [31:0]    hc_q, hc_d;
    logic           dv_q, dv_d, busy_q, busy_d, error_q, error_d;
    logic [KW-1:0]  wr_idx_q, wr_idx_d;
    t_if_ccip_c0_Tx c0_q, c0_d;
    t_if_ccip_c1_Tx c1_q, c1_d;

    logic           start, bad_size, armed, alloc_vld, fill_vld, drain_vld, head_vld, empty;
    logic [7:0]     fill_sum;
    logic [IW-1:0]  fill_idx, alloc_idx;
    logic [PW-1:0]  free_cnt;
    t_ccip_clData   head_dat;
    logic           unused_bits;

    assign unused_bits = ^{bus.ccip_rx.c0.hdr.mdata[15:8]};

    sha_reorder_buf #(.BUF_DEPTH(BUF_DEPTH), .CL_PER_REQ(CL_PER_REQ)) u_rob (
        .clk, .reset_n, .alloc_vld, .alloc_idx, .free_cnt, .empty,
        .fill_vld, .fill_idx, .fill_dat(bus.ccip_rx.c0.data),
        .drain_vld, .head_vld, .head_dat
    );

    assign bus.block       = head_dat;
    assign bus.block_valid = head_vld;
    assign bus.ccip_c0_tx  = c0_q;
    assign bus.ccip_c1_tx  = c1_q;
    assign busy            = busy_q;
    assign error           = error_q;

    always_comb begin
        start    = (hc_control == HC_CONTROL_START) && (hc_q != HC_CONTROL_START) && !busy_q;
        bad_size = (src_size == '0) || ((src_size & t_ccip_clAddr'(CL_PER_REQ - 1)) != '0);
        // Only fill while a job is live so stale responses after reset are dropped.
        fill_sum  = bus.ccip_rx.c0.hdr.mdata[7:0] + {6'd0, bus.ccip_rx.c0.hdr.cl_num};
        fill_idx  = fill_sum[IW-1:0];
        fill_vld  = bus.ccip_rx.c0.rspValid && (bus.ccip_rx.c0.hdr.resp_type == eRSP_RDLINE)
                    && (rd_state_q != RD_IDLE);
        drain_vld = head_vld && bus.block_ready;
        armed     = busy_q && !error_q && (dlv_cnt_q == size_q);

        rd_state_d = rd_state_q;  wr_state_d = wr_state_q;
        rd_cnt_d   = rd_cnt_q;    dlv_cnt_d  = dlv_cnt_q;
        size_d     = size_q;      src_d      = src_q;
        dst_d      = dst_q;       dsm_d      = dsm_q;
        busy_d     = busy_q;      error_d    = error_q;
        wr_idx_d   = wr_idx_q;
        hc_d       = hc_control;
        dv_d       = bus.digest_valid;
        c0_d       = '0;
        c1_d       = '0;
        alloc_vld  = 1'b0;

        if (drain_vld) dlv_cnt_d = dlv_cnt_q + t_ccip_clAddr'(1);

        case (rd_state_q)
            RD_FETCH: begin
                if (rd_cnt_q == size_q) begin
                    rd_state_d = RD_DRAIN;
                end else if (!bus.ccip_rx.c0TxAlmFull && (free_cnt >= PW'(CL_PER_REQ))) begin
                    c0_d.valid       = 1'b1;
                    c0_d.hdr.address = src_q + rd_cnt_q;
                    c0_d.hdr.cl_len  = cl_len_for(CL_PER_REQ);
                    c0_d.hdr.mdata   = 16'(alloc_idx);
                    alloc_vld        = 1'b1;
                    rd_cnt_d         = rd_cnt_q + t_ccip_clAddr'(CL_PER_REQ);
                end
            end
            RD_DRAIN: if (empty) rd_state_d = RD_IDLE;
            default:  ;
        endcase

        case (wr_state_q)
            WR_IDLE: begin
                if (armed && bus.digest_valid && !dv_q) begin
                    wr_state_d = WR_DIGEST;
                    wr_idx_d   = '0;
                end
            end
            WR_DIGEST: begin
                if (!bus.ccip_rx.c1TxAlmFull) begin
                    c1_d.valid       = 1'b1;
                    c1_d.hdr.sop     = 1'b1;
                    c1_d.hdr.cl_len  = eCL_LEN_1;
                    c1_d.hdr.address = dst_q + t_ccip_clAddr'(wr_idx_q);
                    c1_d.data        = bus.digest[int'(wr_idx_q)*512 +: 512];
                    if (wr_idx_q == KW'(DL - 1)) wr_state_d = WR_DSM;
                    else                          wr_idx_d   = wr_idx_q + KW'(1);
                end
            end
            WR_DSM: begin
                if (!bus.ccip_rx.c1TxAlmFull) begin
                    c1_d.valid       = 1'b1;
                    c1_d.hdr.sop     = 1'b1;
                    c1_d.hdr.cl_len  = eCL_LEN_1;
                    c1_d.hdr.address = dsm_q + t_ccip_clAddr'(1);
                    c1_d.data        = t_ccip_clData'(error_q ? DSM_ERR : DSM_OK);
                    wr_state_d       = WR_IDLE;
                    busy_d           = 1'b0;
                end
            end
            default: ;
        endcase

        if (start) begin
            busy_d    = 1'b1;
            error_d   = bad_size;
            size_d    = src_size;
            src_d     = src_addr;
            dst_d     = dst_addr;
            dsm_d     = hc_dsm_base;
            rd_cnt_d  = '0;
            dlv_cnt_d = '0;
            if (bad_size) wr_state_d = WR_DSM;
            else          rd_state_d = RD_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_state_q <= RD_IDLE;  wr_state_q <= WR_IDLE;
            rd_cnt_q   <= '0;       dlv_cnt_q  <= '0;
            size_q     <= '0;       src_q      <= '0;
            dst_q      <= '0;       dsm_q      <= '0;
            hc_q       <= '0;       dv_q       <= 1'b0;
            busy_q     <= 1'b0;     error_q    <= 1'b0;
            wr_idx_q   <= '0;
            c0_q       <= '0;       c1_q       <= '0;
        end else begin
            rd_state_q <= rd_state_d;  wr_state_q <= wr_state_d;
            rd_cnt_q   <= rd_cnt_d;    dlv_cnt_q  <= dlv_cnt_d;
            size_q     <= size_d;      src_q      <= src_d;
            dst_q      <= dst_d;       dsm_q      <= dsm_d;
            hc_q       <= hc_d;        dv_q       <= dv_d;
            busy_q     <= busy_d;      error_q    <= error_d;
            wr_idx_q   <= wr_idx_d;
            c0_q       <= c0_d;        c1_q       <= c1_d;
        end
    end

endmodule

// File: tb/tb_sha_stream_requestor.sv
// Directed bench: host-memory responder, hash-core sink and write log around a 1024-bit-digest requestor.
module tb_sha_stream_requestor;
    import sha_stream_requestor_pkg::*;

    localparam int DW = 1024;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  hc_control;
    t_ccip_clAddr hc_dsm_base, src_addr, src_size, dst_addr;
    logic         busy, error;

    always #5 clk = ~clk;

    sha_stream_requestor_if #(.DIGEST_W(DW)) bus();

    sha_stream_requestor #(.BUF_DEPTH(8), .CL_PER_REQ(2), .DIGEST_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .hc_control(hc_control), .hc_dsm_base(hc_dsm_base),
        .src_addr(src_addr), .src_size(src_size), .dst_addr(dst_addr),
        .bus(bus), .busy(busy), .error(error)
    );

    typedef struct packed {
        t_ccip_clAddr addr;
        logic [15:0]  mdata;
        logic [1:0]   cl;
    } t_line;

    logic         rsp_vld, c0_af, c1_af;
    t_line        rsp_line;
    t_line        rsp_q[$];
    t_ccip_clAddr req_addr_q[$];
    t_ccip_clData dlv_q[$];
    t_ccip_clAddr wr_addr_q[$];
    t_ccip_clData wr_dat_q[$];
    int           rsp_mode, rsp_sent, first_dlv_rsp, n_chk, n_fail;
    bit           rev_go;
    t_ccip_clAddr cur_size;

    function automatic t_ccip_clData line_of(input t_ccip_clAddr a);
        logic [63:0] w;
        w = 64'hC0DE_0000_0000_0000 ^ 64'(a);
        return {8{w}};
    endfunction

    always_comb begin
        bus.ccip_rx                   = '0;
        bus.ccip_rx.c0TxAlmFull       = c0_af;
        bus.ccip_rx.c1TxAlmFull       = c1_af;
        bus.ccip_rx.c0.rspValid       = rsp_vld;
        bus.ccip_rx.c0.hdr.resp_type  = eRSP_RDLINE;
        bus.ccip_rx.c0.hdr.mdata      = rsp_line.mdata;
        bus.ccip_rx.c0.hdr.cl_num     = rsp_line.cl;
        bus.ccip_rx.c0.data           = line_of(rsp_line.addr);
    end

    always @(negedge clk) begin
        if (bus.ccip_c0_tx.valid) begin
            int n;
            n = (bus.ccip_c0_tx.hdr.cl_len == eCL_LEN_4) ? 4 :
                (bus.ccip_c0_tx.hdr.cl_len == eCL_LEN_2) ? 2 : 1;
            req_addr_q.push_back(bus.ccip_c0_tx.hdr.address);
            for (int i = 0; i < n; i++)
                rsp_q.push_back('{addr: bus.ccip_c0_tx.hdr.address + t_ccip_clAddr'(i),
                                  mdata: bus.ccip_c0_tx.hdr.mdata, cl: 2'(i)});
        end
        if (bus.block_valid && bus.block_ready) begin
            if (dlv_q.size() == 0) first_dlv_rsp = rsp_sent;
            dlv_q.push_back(bus.block);
        end
        if (bus.ccip_c1_tx.valid) begin
            wr_addr_q.push_back(bus.ccip_c1_tx.hdr.address);
            wr_dat_q.push_back(bus.ccip_c1_tx.data);
        end
    end

    // Mode 0: in order; mode 1: newest line first once 8 are pending; mode 2: withhold.
    initial begin
        rsp_vld  = 1'b0;
        rsp_line = '0;
        forever begin
            @(posedge clk); #1;
            rsp_vld = 1'b0;
            if (rsp_mode == 1 && rsp_q.size() >= 8) rev_go = 1'b1;
            if (rsp_q.size() > 0 && (rsp_mode == 0 || (rsp_mode == 1 && rev_go))) begin
                rsp_line = (rsp_mode == 1) ? rsp_q.pop_back() : rsp_q.pop_front();
                rsp_vld  = 1'b1;
                rsp_sent++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rsp_q.delete(); req_addr_q.delete(); dlv_q.delete();
        wr_addr_q.delete(); wr_dat_q.delete();
        rsp_sent = 0; first_dlv_rsp = -1; rev_go = 1'b0;
    endtask

    task automatic start_job(input t_ccip_clAddr src, input t_ccip_clAddr size,
                             input t_ccip_clAddr dst, input bit hold);
        clear_logs();
        cur_size   = size;
        src_addr   = src; src_size = size; dst_addr = dst;
        hc_control = HC_CONTROL_START;
        tick(1);
        if (!hold) hc_control = 32'h0;
    endtask

    task automatic finish_job(input bit give_digest, input bit af);
        int wait_c = 0, af_left = 0;
        bit raised = 0, done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (give_digest && !raised && dlv_q.size() == int'(cur_size)) begin
                wait_c++;
                if (wait_c >= 2) begin
                    bus.digest_valid = 1'b1;
                    raised = 1;
                    if (af) begin c1_af = 1'b1; af_left = 3; end
                end
            end
            tick(1);
            if (af_left > 0) begin
                af_left--;
                if (af_left == 0) c1_af = 1'b0;
            end
            if (!busy) done = 1;
        end
        chk("job_done", 64'(done), 64'd1);
        bus.digest_valid = 1'b0;
        c1_af = 1'b0;
        tick(2);
    endtask

    task automatic check_job(input t_ccip_clAddr src, input t_ccip_clAddr size,
                             input t_ccip_clAddr dst);
        t_ccip_clData e;
        chk("req_cnt", 64'(req_addr_q.size()), 64'(size / 2));
        for (int i = 0; i < req_addr_q.size() && i < int'(size / 2); i++)
            chk("req_addr", 64'(req_addr_q[i]), 64'(src + t_ccip_clAddr'(2 * i)));
        chk("dlv_cnt", 64'(dlv_q.size()), 64'(size));
        for (int i = 0; i < dlv_q.size(); i++) begin
            e = line_of(src + t_ccip_clAddr'(i));
            chk("dlv_dat", dlv_q[i][63:0], e[63:0]);
        end
        chk("wr_cnt", 64'(wr_addr_q.size()), 64'd3);
        if (wr_addr_q.size() >= 3) begin
            chk("wr0_addr", 64'(wr_addr_q[0]), 64'(dst));
            chk("wr0_dat", wr_dat_q[0][63:0], 64'hAAAA_1111_0000_0001);
            chk("wr1_addr", 64'(wr_addr_q[1]), 64'(dst + 42'd1));
            chk("wr1_dat", wr_dat_q[1][63:0], 64'hBBBB_2222_0000_0002);
            chk("dsm_addr", 64'(wr_addr_q[2]), 64'h1001);
            chk("dsm_dat", wr_dat_q[2][63:0], 64'd1);
        end
        chk("error_clr", 64'(error), 64'd0);
    endtask

    initial begin
        logic [63:0] b10;
        n_chk = 0; n_fail = 0; rsp_mode = 0; rsp_sent = 0; rev_go = 1'b0; first_dlv_rsp = -1;
        reset_n = 1'b0; hc_control = 32'h0; hc_dsm_base = 42'h1000;
        src_addr = '0; src_size = '0; dst_addr = '0; cur_size = '0;
        c0_af = 1'b0; c1_af = 1'b0;
        bus.block_ready  = 1'b1;
        bus.digest_valid = 1'b0;
        bus.digest = {{8{64'hBBBB_2222_0000_0002}}, {8{64'hAAAA_1111_0000_0001}}};
        tick(3);
        chk("rst_c0_vld", 64'(bus.ccip_c0_tx.valid), 64'd0);
        chk("rst_c1_vld", 64'(bus.ccip_c1_tx.valid), 64'd0);
        chk("rst_blk_vld", 64'(bus.block_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        reset_n = 1'b1;
        tick(2);

        // In-order responses, core always ready.
        start_job(42'h200, 42'd8, 42'h300, 1'b0);
        chk("busy_after_start", 64'(busy), 64'd1);
        finish_job(1'b1, 1'b0);
        check_job(42'h200, 42'd8, 42'h300);

        // Responses newest-first: nothing may reach the core before line 0 lands.
        rsp_mode = 1;
        start_job(42'h400, 42'd8, 42'h300, 1'b0);
        finish_job(1'b1, 1'b0);
        chk("rev_first_after_all", 64'(first_dlv_rsp), 64'd8);
        check_job(42'h400, 42'd8, 42'h300);
        rsp_mode = 0;

        // Core stalls for 20 cycles: issue caps at 8 lines, head line held steady.
        bus.block_ready = 1'b0;
        start_job(42'h800, 42'd16, 42'h300, 1'b0);
        tick(9);
        b10 = bus.block[63:0];
        tick(10);
        chk("stall_req_cnt", 64'(req_addr_q.size()), 64'd4);
        chk("stall_blk_vld", 64'(bus.block_valid), 64'd1);
        chk("stall_blk_hold", bus.block[63:0], b10);
        chk("stall_blk_line0", b10, 64'hC0DE_0000_0000_0800);
        chk("stall_no_dlv", 64'(dlv_q.size()), 64'd0);
        bus.block_ready = 1'b1;
        finish_job(1'b1, 1'b0);
        check_job(42'h800, 42'd16, 42'h300);

        // Write channel almost-full for 3 cycles while the digest is pending.
        start_job(42'hA00, 42'd4, 42'hB00, 1'b0);
        finish_job(1'b1, 1'b1);
        check_job(42'hA00, 42'd4, 42'hB00);

        // Odd length: rejected, DSM only with error status.
        start_job(42'hC00, 42'd3, 42'hD00, 1'b0);
        finish_job(1'b0, 1'b0);
        chk("err_flag", 64'(error), 64'd1);
        chk("err_busy", 64'(busy), 64'd0);
        chk("err_req_cnt", 64'(req_addr_q.size()), 64'd0);
        chk("err_wr_cnt", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() >= 1) begin
            chk("err_dsm_addr", 64'(wr_addr_q[0]), 64'h1001);
            chk("err_dsm_dat", wr_dat_q[0][63:0], 64'd2);
        end

        // Start held high through and past completion: exactly one job.
        start_job(42'h600, 42'd4, 42'h300, 1'b1);
        finish_job(1'b1, 1'b0);
        tick(100);
        chk("held_req_cnt", 64'(req_addr_q.size()), 64'd2);
        chk("held_busy", 64'(busy), 64'd0);
        chk("held_error", 64'(error), 64'd0);
        chk("held_wr_cnt", 64'(wr_addr_q.size()), 64'd3);
        hc_control = 32'h0;
        tick(2);

        // Reset mid-fetch, then release withheld responses: they must be dropped.
        rsp_mode = 2;
        bus.block_ready = 1'b0;
        start_job(42'hE00, 42'd16, 42'h300, 1'b0);
        tick(3);
        chk("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_c0", 64'(bus.ccip_c0_tx.valid), 64'd0);
        chk("mid_rst_blk", 64'(bus.block_valid), 64'd0);
        reset_n = 1'b1;
        rsp_mode = 0;
        bus.block_ready = 1'b1;
        tick(20);
        chk("late_rsp_sent", 64'(rsp_sent > 0), 64'd1);
        chk("late_blk_vld", 64'(bus.block_valid), 64'd0);
        chk("late_dlv_cnt", 64'(dlv_q.size()), 64'd0);
        chk("late_busy", 64'(busy), 64'd0);
        chk("late_wr_cnt", 64'(wr_addr_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
